// File: rtl/float_div_requester_pkg.sv
// Shared IEEE-754 single constants, FSM encoding and classification helpers for the divider front end.
// Pure definitions; no timing or flow-control behaviour of its own.
package float_div_requester_pkg;

  localparam logic [31:0] FP_QNAN       = 32'h7FC00000;
  localparam logic [30:0] FP_INF        = 31'h7F800000;
  localparam logic [31:0] FP_ONE        = 32'h3F800000;
  localparam logic [7:0]  EXP_MAX       = 8'hFF;
  localparam logic [7:0]  REC_EXP_LIMIT = 8'd253;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic        hit;
    logic [31:0] val;
  } special_t;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == EXP_MAX) && (f[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/float_div_requester_mult.sv
// Combinational single-precision multiplier (round-to-nearest-even, denormals flushed to zero).
// Zero latency; no flow control, output follows inputs.
module floatMult
  import float_div_requester_pkg::*;
(
  input  logic [31:0] float_a_i,
  input  logic [31:0] float_b_i,
  output logic [31:0] product_o
);

  logic               sign;
  logic [7:0]         ea;
  logic [7:0]         eb;
  logic [47:0]        prod;
  logic [22:0]        mant;
  logic               guard;
  logic               sticky;
  logic               rnd;
  logic [23:0]        mant_r;
  logic signed [9:0]  exp_s;

  always_comb begin
    sign   = float_a_i[31] ^ float_b_i[31];
    ea     = float_a_i[30:23];
    eb     = float_b_i[30:23];
    prod   = {1'b1, float_a_i[22:0]} * {1'b1, float_b_i[22:0]};
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_s  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    end
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, rnd};
    // Rounding carry-out leaves the fraction at zero; only the exponent moves.
    if (mant_r[23]) begin
      exp_s = exp_s + 10'sd1;
    end

    if (is_nan(float_a_i) || is_nan(float_b_i) ||
        ((ea == EXP_MAX) && (eb == 8'd0)) || ((eb == EXP_MAX) && (ea == 8'd0))) begin
      product_o = FP_QNAN;
    end else if ((ea == EXP_MAX) || (eb == EXP_MAX)) begin
      product_o = {sign, FP_INF};
    end else if ((ea == 8'd0) || (eb == 8'd0) || (exp_s <= 10'sd0)) begin
      product_o = {sign, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      product_o = {sign, FP_INF};
    end else begin
      product_o = {sign, exp_s[7:0], mant_r[22:0]};
    end
  end

endmodule

// File: rtl/float_div_requester.sv
// Divider front end: owns the reciprocal unit's enable/ack handshake, then multiplies by 1/divisor.
// One op in flight; in_ready low from accept until the result is taken on out_valid/out_ready.
module float_div_requester
  import float_div_requester_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_p,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  rec_enable,
  output logic [DATA_WIDTH-1:0] rec_number,
  input  logic [DATA_WIDTH-1:0] rec_result,
  input  logic                  rec_ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic                  err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   rec_q, rec_d;
  logic [31:0]   quot_q, quot_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_en_q;
  logic [31:0]   mult_res;
  special_t      spec;

  // Operand pairs resolved without the reciprocal unit; hit=0 means a request is needed.
  function automatic special_t classify(input logic [31:0] a, input logic [31:0] b);
    special_t r;
    logic     s;
    s     = a[31] ^ b[31];
    r.hit = 1'b1;
    r.val = FP_QNAN;
    if (is_nan(a) || is_nan(b)) begin
      r.val = FP_QNAN;
    end else if (b[30:23] == 8'd0) begin
      r.val = (a[30:23] == 8'd0) ? FP_QNAN : {s, FP_INF};
    end else if (b[30:23] == EXP_MAX) begin
      r.val = (a[30:23] == EXP_MAX) ? FP_QNAN : {s, 31'd0};
    end else if ((b[30:23] >= REC_EXP_LIMIT) || (a[30:23] == 8'd0)) begin
      r.val = {s, 31'd0};
    end else if (a[30:23] == EXP_MAX) begin
      r.val = {s, EXP_MAX, 23'd0};
    end else begin
      r.hit = 1'b0;
      r.val = 32'd0;
    end
    return r;
  endfunction

  floatMult u_mult (
    .float_a_i (a_q),
    .float_b_i (rec_q),
    .product_o (mult_res)
  );

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rec_q    <= 32'd0;
      quot_q   <= 32'd0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rec_q    <= rec_d;
      quot_q   <= quot_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rec_d   = rec_q;
    quot_d  = quot_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    spec    = classify(dividend, divisor);
    case (state_q)
      ST_IDLE: begin
        if (in_valid && rdy_en_q) begin
          a_d   = dividend;
          b_d   = divisor;
          cnt_d = '0;
          if (spec.hit) begin
            quot_d  = spec.val;
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Ack on the final timeout edge still counts as success.
        if (rec_ack) begin
          rec_d   = rec_result;
          state_d = ST_MUL;
        end else if (cnt_q == CNT_LAST) begin
          quot_d  = FP_QNAN;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_MUL: begin
        quot_d  = mult_res;
        err_d   = 1'b0;
        state_d = ST_DONE;
      end
      default: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign in_ready   = (state_q == ST_IDLE) && rdy_en_q;
  assign rec_enable = (state_q == ST_REQ);
  assign rec_number = b_q;
  assign out_valid  = (state_q == ST_DONE);
  assign quotient   = quot_q;
  assign err        = err_q;

endmodule
